// File: rtl/cf_sequencer_if.sv
// cf_sequencer_if
//   Bundles the instruction-offer handshake, the architectural register
//   inputs/writebacks and the stack memory port of the control-flow
//   sequencer.
//   Modports:
//     slave  - the sequencer (accepts instructions, issues stack traffic)
//     master - the surrounding core (offers instructions, answers memory)
//   Signals:
//     instr_valid/instr_ready  instruction offer handshake
//     opc, instr_len, address  decoded command, length, displacement/target
//     eflags, ecx, esp         architectural state sampled on accept
//     eip, retire              architectural EIP and commit pulse
//     mem_*                    stack memory request/response
//     esp_we/esp_wdata         ESP writeback strobe and value
//     ecx_we/ecx_wdata         ECX writeback strobe and value
interface cf_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  opc;
    logic [3:0]  instr_len;
    logic [31:0] address;
    logic [31:0] eflags;
    logic [31:0] ecx;
    logic [31:0] esp;
    logic [31:0] eip;
    logic        retire;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        esp_we;
    logic [31:0] esp_wdata;
    logic        ecx_we;
    logic [31:0] ecx_wdata;

    modport slave (
        input  instr_valid, opc, instr_len, address, eflags, ecx, esp,
               mem_rdata, mem_ack,
        output instr_ready, eip, retire, mem_req, mem_we, mem_addr,
               mem_wdata, esp_we, esp_wdata, ecx_we, ecx_wdata
    );

    modport master (
        output instr_valid, opc, instr_len, address, eflags, ecx, esp,
               mem_rdata, mem_ack,
        input  instr_ready, eip, retire, mem_req, mem_we, mem_addr,
               mem_wdata, esp_we, esp_wdata, ecx_we, ecx_wdata
    );
endinterface

// File: rtl/cf_sequencer.sv
// cf_sequencer_pkg
//   Command opcode encoding shared by the sequencer and its users.
//   Conditional jumps occupy 7'h10..7'h1F; the low nibble is the x86
//   condition code (O, NO, B, AE, E, NE, BE, A, S, NS, P, NP, L, GE, LE, G).
package cf_sequencer_pkg;
    localparam logic [6:0] CMD_NOP    = 7'h00;
    localparam logic [6:0] CMD_JMPR   = 7'h01;
    localparam logic [6:0] CMD_JMPI   = 7'h02;
    localparam logic [6:0] CMD_CALLR  = 7'h03;
    localparam logic [6:0] CMD_CALLI  = 7'h04;
    localparam logic [6:0] CMD_RET    = 7'h05;
    localparam logic [6:0] CMD_LOOP   = 7'h06;
    localparam logic [6:0] CMD_LOOPE  = 7'h07;
    localparam logic [6:0] CMD_LOOPNE = 7'h08;
    localparam logic [6:0] CMD_JCXZ   = 7'h09;
    localparam logic [6:0] CMD_JO     = 7'h10;
    localparam logic [6:0] CMD_JB     = 7'h12;
    localparam logic [6:0] CMD_JE     = 7'h14;
    localparam logic [6:0] CMD_JNE    = 7'h15;
    localparam logic [6:0] CMD_JA     = 7'h17;
    localparam logic [6:0] CMD_JS     = 7'h18;
    localparam logic [6:0] CMD_JP     = 7'h1A;
    localparam logic [6:0] CMD_JL     = 7'h1C;
    localparam logic [6:0] CMD_JG     = 7'h1F;
endpackage

// cfu
//   Combinational control flow unit: picks the next EIP from the sequential
//   address (seq), a relative or absolute target and the condition inputs.
//   Ports:
//     opc          command opcode
//     seq          address of the following instruction
//     address      displacement (relative ops) or absolute target
//     cf,pf,zf,sf,of  EFLAGS condition bits
//     ecx_is_zero  ECX zero test prepared by the sequencer
//     next_eip     resulting EIP
module cfu
    import cf_sequencer_pkg::*;
(
    input  logic [6:0]  opc,
    input  logic [31:0] seq,
    input  logic [31:0] address,
    input  logic        cf,
    input  logic        pf,
    input  logic        zf,
    input  logic        sf,
    input  logic        of,
    input  logic        ecx_is_zero,
    output logic [31:0] next_eip
);
    logic [31:0] rel_target;
    logic        base_cond;
    logic        jcc_taken;

    assign rel_target = seq + address;

    // Odd condition codes are the negation of the preceding even one.
    always_comb begin
        base_cond = 1'b0;
        case (opc[3:1])
            3'd0: base_cond = of;
            3'd1: base_cond = cf;
            3'd2: base_cond = zf;
            3'd3: base_cond = cf | zf;
            3'd4: base_cond = sf;
            3'd5: base_cond = pf;
            3'd6: base_cond = sf ^ of;
            3'd7: base_cond = zf | (sf ^ of);
            default: base_cond = 1'b0;
        endcase
    end

    assign jcc_taken = base_cond ^ opc[0];

    always_comb begin
        next_eip = seq;
        case (opc)
            CMD_JMPR, CMD_CALLR:         next_eip = rel_target;
            CMD_JMPI, CMD_CALLI, CMD_RET: next_eip = address;
            CMD_LOOP:   if (!ecx_is_zero)        next_eip = rel_target;
            CMD_LOOPE:  if (!ecx_is_zero && zf)  next_eip = rel_target;
            CMD_LOOPNE: if (!ecx_is_zero && !zf) next_eip = rel_target;
            CMD_JCXZ:   if (ecx_is_zero)         next_eip = rel_target;
            default: begin
                if (opc[6:4] == 3'b001 && jcc_taken) next_eip = rel_target;
            end
        endcase
    end
endmodule

// cf_sequencer
//   Owns the architectural EIP. Accepts one decoded instruction at a time,
//   performs the CALL push / RET pop on the stack port, decrements ECX for
//   the LOOP family and commits the CFU's next EIP with a one-cycle retire.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    cf_sequencer_if.slave (instruction, state, stack and writebacks)
module cf_sequencer
    import cf_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    cf_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PUSH, POP, COMMIT} state_t;

    state_t      state;
    logic [6:0]  opc_p0;
    logic [3:0]  len_p0;
    logic [31:0] addr_p0;
    logic [4:0]  flags_p0;
    logic [31:0] ecx_p0;
    logic [31:0] eip_r;
    logic        instr_ready_r;
    logic        retire_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] esp_wdata_r;
    logic        ecx_we_r;
    logic [31:0] ecx_wdata_r;

    logic [31:0] seq;
    logic        ecx_is_zero;
    logic [31:0] next_eip;
    logic        unused_eflags;

    function automatic logic is_loop_op(input logic [6:0] op);
        return (op == CMD_LOOP) || (op == CMD_LOOPE) || (op == CMD_LOOPNE);
    endfunction

    assign unused_eflags = ^{bus.eflags[31:12], bus.eflags[10:8],
                             bus.eflags[5:3], bus.eflags[1]};

    assign seq = eip_r + {28'd0, len_p0};

    // LOOPcc tests the already-decremented count; JCXZ tests ECX as-is.
    assign ecx_is_zero = is_loop_op(opc_p0) ? ((ecx_p0 - 32'd1) == 32'd0)
                                            : (ecx_p0 == 32'd0);

    cfu u_cfu (
        .opc         (opc_p0),
        .seq         (seq),
        .address     (addr_p0),
        .cf          (flags_p0[0]),
        .pf          (flags_p0[1]),
        .zf          (flags_p0[2]),
        .sf          (flags_p0[3]),
        .of          (flags_p0[4]),
        .ecx_is_zero (ecx_is_zero),
        .next_eip    (next_eip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            opc_p0        <= CMD_NOP;
            len_p0        <= 4'd0;
            addr_p0       <= 32'd0;
            flags_p0      <= 5'd0;
            ecx_p0        <= 32'd0;
            eip_r         <= RESET_EIP;
            instr_ready_r <= 1'b1;
            retire_r      <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'd0;
            mem_wdata_r   <= 32'd0;
            esp_wdata_r   <= 32'd0;
            ecx_we_r      <= 1'b0;
            ecx_wdata_r   <= 32'd0;
        end else begin
            case (state)
                // Accept: capture the instruction and pick the path
                IDLE: begin
                    if (bus.instr_valid && instr_ready_r) begin
                        opc_p0        <= bus.opc;
                        len_p0        <= bus.instr_len;
                        addr_p0       <= bus.address;
                        flags_p0      <= {bus.eflags[11], bus.eflags[7], bus.eflags[6],
                                          bus.eflags[2], bus.eflags[0]};
                        ecx_p0        <= bus.ecx;
                        instr_ready_r <= 1'b0;
                        if (bus.opc == CMD_CALLR || bus.opc == CMD_CALLI) begin
                            state       <= PUSH;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= bus.esp - 32'd4;
                            mem_wdata_r <= eip_r + {28'd0, bus.instr_len};
                            esp_wdata_r <= bus.esp - 32'd4;
                        end else if (bus.opc == CMD_RET) begin
                            state       <= POP;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= bus.esp;
                            esp_wdata_r <= bus.esp + 32'd4;
                        end else begin
                            state    <= COMMIT;
                            retire_r <= 1'b1;
                            if (is_loop_op(bus.opc)) begin
                                ecx_we_r    <= 1'b1;
                                ecx_wdata_r <= bus.ecx - 32'd1;
                            end
                        end
                    end
                end
                // Stack write of the return address
                PUSH: begin
                    if (bus.mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        retire_r  <= 1'b1;
                        state     <= COMMIT;
                    end
                end
                // Stack read; popped word becomes the CFU target
                POP: begin
                    if (bus.mem_ack) begin
                        addr_p0   <= bus.mem_rdata;
                        mem_req_r <= 1'b0;
                        retire_r  <= 1'b1;
                        state     <= COMMIT;
                    end
                end
                // Commit the CFU result
                COMMIT: begin
                    eip_r         <= next_eip;
                    retire_r      <= 1'b0;
                    ecx_we_r      <= 1'b0;
                    instr_ready_r <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_r;
    assign bus.eip         = eip_r;
    assign bus.retire      = retire_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    // ESP writeback lands in the ack cycle itself, so it is decoded from the
    // live ack rather than registered.
    assign bus.esp_we      = ((state == PUSH) || (state == POP)) && bus.mem_ack;
    assign bus.esp_wdata   = esp_wdata_r;
    assign bus.ecx_we      = ecx_we_r;
    assign bus.ecx_wdata   = ecx_wdata_r;
endmodule

// File: tb/tb_cf_sequencer.sv
// tb_cf_sequencer
//   Self-checking bench for cf_sequencer: directed scenarios followed by
//   randomized instructions compared against an architectural EIP model.
module tb_cf_sequencer;
    import cf_sequencer_pkg::*;

    localparam logic [31:0] RST_EIP = 32'h0000_1000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] m_eip;

    cf_sequencer_if bus ();

    cf_sequencer #(.RESET_EIP(RST_EIP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // x86 condition table evaluated directly from named flags.
    function automatic bit cc_true(input logic [3:0] cc, input logic [31:0] f);
        bit c, p, z, s, o;
        c = f[0]; p = f[2]; z = f[6]; s = f[7]; o = f[11];
        case (cc)
            4'h0: return o;
            4'h1: return !o;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return z;
            4'h5: return !z;
            4'h6: return c || z;
            4'h7: return !c && !z;
            4'h8: return s;
            4'h9: return !s;
            4'hA: return p;
            4'hB: return !p;
            4'hC: return s != o;
            4'hD: return s == o;
            4'hE: return z || (s != o);
            default: return !z && (s == o);
        endcase
    endfunction

    function automatic logic [31:0] ref_next(input logic [6:0] op, input logic [31:0] eip,
                                             input logic [3:0] len, input logic [31:0] addr,
                                             input logic [31:0] f, input logic [31:0] cnt,
                                             input logic [31:0] popped);
        logic [31:0] nxt, rel, left;
        nxt  = eip + 32'(len);
        rel  = nxt + addr;
        left = cnt - 1;
        case (op)
            CMD_JMPR, CMD_CALLR: return rel;
            CMD_JMPI, CMD_CALLI: return addr;
            CMD_RET:             return popped;
            CMD_LOOP:            return (left != 0) ? rel : nxt;
            CMD_LOOPE:           return (left != 0 && f[6]) ? rel : nxt;
            CMD_LOOPNE:          return (left != 0 && !f[6]) ? rel : nxt;
            CMD_JCXZ:            return (cnt == 0) ? rel : nxt;
            default: begin
                if (op >= 7'h10 && op <= 7'h1F) return cc_true(op[3:0], f) ? rel : nxt;
                return nxt;
            end
        endcase
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("instr_ready", 32'(bus.instr_ready), 32'd1);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [3:0] len, input logic [31:0] addr,
                             input logic [31:0] fl, input logic [31:0] cnt, input logic [31:0] sp,
                             input logic [31:0] rdata, input int dly);
        logic [31:0] exp_eip, seq;
        bit is_call, is_ret, is_loop;
        is_call = (op == CMD_CALLR) || (op == CMD_CALLI);
        is_ret  = (op == CMD_RET);
        is_loop = (op == CMD_LOOP) || (op == CMD_LOOPE) || (op == CMD_LOOPNE);
        wait_ready();
        check_val("eip_before", bus.eip, m_eip);
        seq     = m_eip + 32'(len);
        exp_eip = ref_next(op, m_eip, len, addr, fl, cnt, rdata);
        bus.opc = op; bus.instr_len = len; bus.address = addr;
        bus.eflags = fl; bus.ecx = cnt; bus.esp = sp;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs: they must be ignored once the instruction is taken.
        bus.instr_valid = 1'b0;
        bus.opc = 7'($urandom); bus.instr_len = 4'($urandom); bus.address = $urandom;
        bus.eflags = $urandom; bus.ecx = $urandom; bus.esp = $urandom;
        if (is_call || is_ret) begin
            check_val("mem_req", 32'(bus.mem_req), 32'd1);
            check_val("mem_we", 32'(bus.mem_we), 32'(is_call));
            check_val("mem_addr", bus.mem_addr, is_call ? sp - 32'd4 : sp);
            if (is_call) check_val("mem_wdata", bus.mem_wdata, seq);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check_val("mem_req_hold", 32'(bus.mem_req), 32'd1);
                check_val("mem_addr_hold", bus.mem_addr, is_call ? sp - 32'd4 : sp);
                if (is_call) check_val("mem_wdata_hold", bus.mem_wdata, seq);
                check_val("esp_we_wait", 32'(bus.esp_we), 32'd0);
                check_val("retire_wait", 32'(bus.retire), 32'd0);
            end
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rdata;
            #1;
            check_val("esp_we_ack", 32'(bus.esp_we), 32'd1);
            check_val("esp_wdata", bus.esp_wdata, is_call ? sp - 32'd4 : sp + 32'd4);
            check_val("retire_ack", 32'(bus.retire), 32'd0);
            @(negedge clk);
            check_val("esp_we_post", 32'(bus.esp_we), 32'd0);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
            check_val("mem_req_drop", 32'(bus.mem_req), 32'd0);
            check_val("retire", 32'(bus.retire), 32'd1);
            check_val("ecx_we_stack", 32'(bus.ecx_we), 32'd0);
        end else begin
            check_val("retire", 32'(bus.retire), 32'd1);
            check_val("mem_req_idle", 32'(bus.mem_req), 32'd0);
            check_val("esp_we_none", 32'(bus.esp_we), 32'd0);
            check_val("ecx_we", 32'(bus.ecx_we), 32'(is_loop));
            if (is_loop) check_val("ecx_wdata", bus.ecx_wdata, cnt - 32'd1);
        end
        @(negedge clk);
        check_val("retire_end", 32'(bus.retire), 32'd0);
        check_val("ecx_we_end", 32'(bus.ecx_we), 32'd0);
        check_val("eip", bus.eip, exp_eip);
        check_val("ready_after", 32'(bus.instr_ready), 32'd1);
        m_eip = exp_eip;
    endtask

    logic [6:0] op_list [19];

    initial begin
        logic [6:0]  op;
        logic [31:0] cnt;
        n_cmp = 0;
        n_err = 0;
        m_eip = RST_EIP;
        op_list = '{CMD_NOP, CMD_JMPR, CMD_JMPI, CMD_CALLR, CMD_CALLI, CMD_RET,
                    CMD_LOOP, CMD_LOOPE, CMD_LOOPNE, CMD_JCXZ, CMD_JO, CMD_JB,
                    CMD_JE, CMD_JNE, CMD_JA, CMD_JS, CMD_JP, CMD_JL, CMD_JG};
        rst_n = 1'b0;
        bus.instr_valid = 1'b0; bus.opc = 7'd0; bus.instr_len = 4'd0;
        bus.address = 32'd0; bus.eflags = 32'd0; bus.ecx = 32'd0; bus.esp = 32'd0;
        bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_eip", bus.eip, RST_EIP);
        check_val("rst_ready", 32'(bus.instr_ready), 32'd1);
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_retire", 32'(bus.retire), 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        check_val("rst_ecx_wdata", bus.ecx_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("eip_after_release", bus.eip, RST_EIP);

        // JE taken / not taken
        run_instr(CMD_JE, 4'd2, 32'h10, 32'h40, 32'd0, 32'd0, 32'd0, 0);
        check_val("je_taken", bus.eip, 32'h1012);
        run_instr(CMD_JMPI, 4'd3, 32'h1000, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_instr(CMD_JE, 4'd2, 32'h10, 32'h0, 32'd0, 32'd0, 32'd0, 0);
        check_val("je_not_taken", bus.eip, 32'h1002);

        // CALLi with delayed ack, then RET
        run_instr(CMD_JMPI, 4'd2, 32'h2000, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_instr(CMD_CALLI, 4'd5, 32'h3000, 32'd0, 32'd0, 32'h8000, 32'd0, 3);
        check_val("calli_eip", bus.eip, 32'h3000);
        run_instr(CMD_RET, 4'd1, 32'd0, 32'd0, 32'd0, 32'h7FFC, 32'h2005, 1);
        check_val("ret_eip", bus.eip, 32'h2005);

        // CALLr with ESP wrapping below zero
        run_instr(CMD_CALLR, 4'd5, 32'h100, 32'd0, 32'd0, 32'd0, 32'd0, 0);

        // LOOP boundaries
        run_instr(CMD_JMPI, 4'd2, 32'h1000, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_instr(CMD_LOOP, 4'd2, 32'hFFFF_FFF0, 32'd0, 32'd5, 32'd0, 32'd0, 0);
        check_val("loop5_eip", bus.eip, 32'h0FF2);
        run_instr(CMD_JMPI, 4'd2, 32'h1000, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_instr(CMD_LOOP, 4'd2, 32'hFFFF_FFF0, 32'd0, 32'd1, 32'd0, 32'd0, 0);
        check_val("loop1_eip", bus.eip, 32'h1002);
        run_instr(CMD_JMPI, 4'd2, 32'h1000, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_instr(CMD_LOOP, 4'd2, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        check_val("loop0_eip", bus.eip, 32'h0FF2);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            op  = op_list[$urandom_range(0, 18)];
            cnt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            run_instr(op, 4'($urandom_range(1, 15)), $urandom, $urandom, cnt,
                      $urandom, $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of a push; a late ack must be ignored
        wait_ready();
        bus.opc = CMD_CALLI; bus.instr_len = 4'd5; bus.address = 32'h5000;
        bus.esp = 32'h9000; bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check_val("push_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_mid_esp_we", 32'(bus.esp_we), 32'd0);
        check_val("rst_mid_eip", bus.eip, RST_EIP);
        check_val("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        check_val("late_ack_esp_we", 32'(bus.esp_we), 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_val("late_ack_retire", 32'(bus.retire), 32'd0);
        check_val("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("late_ack_eip", bus.eip, RST_EIP);
        m_eip = RST_EIP;
        run_instr(CMD_JMPR, 4'd2, 32'h20, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        check_val("post_rst_jmp", bus.eip, 32'h1022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
